// File: rtl/rs_encoder_stream.sv
// ---------------------------------------------------------------------------
// rs_encoder_stream
//   Systematic Reed-Solomon encoder over GF(2^8) (primitive polynomial 0x11D)
//   with a valid/ready byte stream on both sides. Message bytes are forwarded
//   unchanged and followed by NPAR parity bytes, highest-degree parity first.
//   Message length is runtime variable (shortened code); a message that
//   reaches K_MAX = 255 - NPAR bytes without s_last is closed automatically
//   and flagged on err_len.
//
// Ports
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   s_valid   in   input byte valid
//   s_ready   out  encoder accepts a byte this cycle
//   s_data    in   message byte
//   s_last    in   final message byte of the codeword
//   m_valid   out  output byte valid
//   m_ready   in   downstream accepts the output byte
//   m_data    out  codeword byte (message, then parity)
//   m_sop     out  first byte of the codeword
//   m_eop     out  last parity byte
//   m_parity  out  current byte is parity
//   err_len   out  one-cycle pulse: message forced closed at K_MAX bytes
// ---------------------------------------------------------------------------

// Multiply by a GF(2^8) constant; with C fixed this reduces to an XOR network.
module gf256_const_mult #(
    parameter logic [7:0] C = 8'h01
) (
    input  logic [7:0] i_a,
    output logic [7:0] o_p
);
    logic [7:0] w_acc;
    logic [7:0] w_sh;

    always_comb begin
        w_acc = '0;
        w_sh  = i_a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (C[i]) begin
                w_acc = w_acc ^ w_sh;
            end
            w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? 8'h1D : 8'h00);
        end
    end

    assign o_p = w_acc;
endmodule

module rs_encoder_stream #(
    parameter int unsigned         NPAR     = 16,
    parameter logic [8*NPAR-1:0]   GEN_POLY = 128'h76_34_67_1F_68_7E_BB_E8_11_38_B7_31_64_51_2C_4F
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_sop,
    output logic       m_eop,
    output logic       m_parity,
    output logic       err_len
);
    localparam int unsigned PW    = $clog2(NPAR);
    localparam logic [7:0]  K_MAX = 8'(255 - NPAR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MSG,
        S_PAR
    } state_t;

    state_t        r_state;
    logic [7:0]    r_lfsr [NPAR];
    logic [PW-1:0] r_par_cnt;
    logic [7:0]    r_cnt;
    logic          r_m_valid;
    logic [7:0]    r_m_data;
    logic          r_m_sop;
    logic          r_m_eop;
    logic          r_m_parity;
    logic          r_err_len;

    logic          w_ld;
    logic          w_s_ready;
    logic          w_s_acc;
    logic [7:0]    w_fb;
    logic [7:0]    w_cnt_nxt;
    logic          w_at_kmax;
    logic          w_last;
    logic [7:0]    w_prod [NPAR];

    // One constant multiplier per generator coefficient, all fed by the feedback byte.
    for (genvar gi = 0; gi < NPAR; gi++) begin : g_mult
        gf256_const_mult #(
            .C (GEN_POLY[8*gi +: 8])
        ) u_mult (
            .i_a (w_fb),
            .o_p (w_prod[gi])
        );
    end

    // The output register may be (re)loaded when empty or being drained.
    assign w_ld      = !r_m_valid || m_ready;
    // Held low while reset is asserted so upstream never sees a stray ready.
    assign w_s_ready = rst_n && (r_state != S_PAR) && w_ld;
    assign w_s_acc   = s_valid && w_s_ready;
    assign w_fb      = r_lfsr[NPAR-1] ^ s_data;
    assign w_cnt_nxt = ((r_state == S_IDLE) ? 8'd0 : r_cnt) + 8'd1;
    assign w_at_kmax = (w_cnt_nxt == K_MAX);
    assign w_last    = s_last || w_at_kmax;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            for (int unsigned i = 0; i < NPAR; i++) begin
                r_lfsr[i] <= '0;
            end
            r_par_cnt  <= '0;
            r_cnt      <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_sop    <= 1'b0;
            r_m_eop    <= 1'b0;
            r_m_parity <= 1'b0;
            r_err_len  <= 1'b0;
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                S_IDLE, S_MSG: begin
                    if (w_s_acc) begin
                        r_lfsr[0] <= w_prod[0];
                        for (int unsigned i = 1; i < NPAR; i++) begin
                            r_lfsr[i] <= w_prod[i] ^ r_lfsr[i-1];
                        end
                        r_m_valid  <= 1'b1;
                        r_m_data   <= s_data;
                        r_m_sop    <= (r_state == S_IDLE);
                        r_m_eop    <= 1'b0;
                        r_m_parity <= 1'b0;
                        r_cnt      <= w_cnt_nxt;
                        if (w_last) begin
                            r_state   <= S_PAR;
                            r_par_cnt <= PW'(NPAR - 1);
                            // w_last without s_last can only mean the K_MAX limit hit
                            r_err_len <= !s_last;
                        end else begin
                            r_state <= S_MSG;
                        end
                    end else begin
                        if (m_ready) begin
                            r_m_valid <= 1'b0;
                        end
                        if (r_state == S_IDLE) begin
                            r_cnt <= '0;
                        end
                    end
                end
                S_PAR: begin
                    if (w_ld) begin
                        r_m_valid  <= 1'b1;
                        r_m_data   <= r_lfsr[NPAR-1];
                        r_m_sop    <= 1'b0;
                        r_m_parity <= 1'b1;
                        r_m_eop    <= (r_par_cnt == '0);
                        r_lfsr[0]  <= '0;
                        for (int unsigned i = 1; i < NPAR; i++) begin
                            r_lfsr[i] <= r_lfsr[i-1];
                        end
                        r_par_cnt <= r_par_cnt - 1'b1;
                        if (r_par_cnt == '0) begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ready  = w_s_ready;
    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_sop    = r_m_sop;
    assign m_eop    = r_m_eop;
    assign m_parity = r_m_parity;
    assign err_len  = r_err_len;
endmodule

// File: tb/tb_rs_encoder_stream.sv
// ---------------------------------------------------------------------------
// tb_rs_encoder_stream
//   Self-checking bench for rs_encoder_stream. Two instances: NPAR = 16 with
//   the default generator and NPAR = 8 with a generator built from roots
//   alpha^0..alpha^7. Expected codewords come from polynomial long division
//   of m(x)*x^NPAR by g(x); codewords are also evaluated at every root of g.
// ---------------------------------------------------------------------------
module tb_rs_encoder_stream;
    typedef logic [7:0] byte_q [$];
    typedef struct packed {
        logic [7:0]  d;
        logic        sop;
        logic        eop;
        logic        par;
        int unsigned cyc;
    } rec_t;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    // Product of (x + alpha^k), k = 0..7, low coefficient first.
    function automatic logic [63:0] mk_gen8();
        logic [8:0][7:0] g;
        logic [7:0]      root;
        g    = '0;
        g[0] = 8'h01;
        root = 8'h01;
        for (int k = 0; k < 8; k++) begin
            for (int i = 8; i > 0; i--) g[i] = g[i-1] ^ gmul(g[i], root);
            g[0] = gmul(g[0], root);
            root = gmul(root, 8'h02);
        end
        return g[7:0];
    endfunction

    localparam logic [127:0] GP16 = 128'h76_34_67_1F_68_7E_BB_E8_11_38_B7_31_64_51_2C_4F;
    localparam logic [63:0]  GP8  = mk_gen8();

    logic       clk;
    logic       rst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_last;
    logic       m_ready;
    logic       sel;
    logic       stall;

    logic       s16_valid, s16_ready, m16_valid, m16_sop, m16_eop, m16_par, m16_err;
    logic [7:0] m16_data;
    logic       s8_valid, s8_ready, m8_valid, m8_sop, m8_eop, m8_par, m8_err;
    logic [7:0] m8_data;

    assign s16_valid = s_valid && !sel;
    assign s8_valid  = s_valid && sel;

    rs_encoder_stream #(.NPAR(16), .GEN_POLY(GP16)) u_dut16 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s16_valid), .s_ready(s16_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m16_valid), .m_ready(m_ready), .m_data(m16_data),
        .m_sop(m16_sop), .m_eop(m16_eop), .m_parity(m16_par), .err_len(m16_err)
    );

    rs_encoder_stream #(.NPAR(8), .GEN_POLY(GP8)) u_dut8 (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s8_valid), .s_ready(s8_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m8_valid), .m_ready(m_ready), .m_data(m8_data),
        .m_sop(m8_sop), .m_eop(m8_eop), .m_parity(m8_par), .err_len(m8_err)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        m_ready = stall ? ($urandom_range(0, 99) < 55) : 1'b1;
    end

    // Output monitor: transfers, hold stability under backpressure, err pulses.
    rec_t        obs16 [$];
    rec_t        obs8  [$];
    logic        h16 = 1'b0, h8 = 1'b0;
    logic [11:0] hv16, hv8;
    int unsigned err16_cnt = 0, err8_cnt = 0, err16_cyc = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            h16 = 1'b0;
            h8  = 1'b0;
        end else begin
            if (h16) chk("hold16", {m16_valid, m16_data, m16_sop, m16_eop, m16_par}, hv16);
            h16  = m16_valid && !m_ready;
            hv16 = {m16_valid, m16_data, m16_sop, m16_eop, m16_par};
            if (m16_valid && m_ready) obs16.push_back('{m16_data, m16_sop, m16_eop, m16_par, cyc});
            if (m16_err) begin
                err16_cnt++;
                err16_cyc = cyc;
            end
            if (h8) chk("hold8", {m8_valid, m8_data, m8_sop, m8_eop, m8_par}, hv8);
            h8  = m8_valid && !m_ready;
            hv8 = {m8_valid, m8_data, m8_sop, m8_eop, m8_par};
            if (m8_valid && m_ready) obs8.push_back('{m8_data, m8_sop, m8_eop, m8_par, cyc});
            if (m8_err) err8_cnt++;
        end
    end

    function automatic logic [7:0] gcoef(input int np, input int k);
        logic [127:0] t16;
        logic [63:0]  t8;
        t16 = GP16;
        t8  = GP8;
        return (np == 8) ? t8[8*k +: 8] : t16[8*k +: 8];
    endfunction

    byte_q roots16, roots8;

    task automatic find_roots(input int np, output byte_q r);
        logic [7:0] x, v;
        x = 8'h01;
        r = {};
        for (int e = 0; e < 255; e++) begin
            v = 8'h01;
            for (int k = np - 1; k >= 0; k--) v = gmul(v, x) ^ gcoef(np, k);
            if (v == 8'h00) r.push_back(x);
            x = gmul(x, 8'h02);
        end
    endtask

    // Long division of m(x)*x^np by monic g(x); remainder follows the message.
    task automatic ref_codeword(input int np, input byte_q msg, output byte_q cw);
        byte_q      a;
        logic [7:0] c;
        a = msg;
        for (int k = 0; k < np; k++) a.push_back(8'h00);
        for (int j = 0; j < msg.size(); j++) begin
            c = a[j];
            if (c != 8'h00)
                for (int k = 1; k <= np; k++) a[j+k] = a[j+k] ^ gmul(c, gcoef(np, np - k));
        end
        cw = msg;
        for (int k = 0; k < np; k++) cw.push_back(a[msg.size() + k]);
    endtask

    task automatic rand_msg(input int n, output byte_q q);
        q = {};
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic drive(input byte_q msg, input int gap_pct, output int unsigned lowcnt);
        int unsigned idx, guard;
        bit          acc;
        idx    = 0;
        guard  = 0;
        lowcnt = 0;
        while (idx < msg.size() && guard < 20000) begin
            s_valid = ($urandom_range(0, 99) >= gap_pct);
            s_data  = msg[idx];
            s_last  = (idx == msg.size() - 1);
            @(negedge clk);
            acc = s_valid && (sel ? s8_ready : s16_ready);
            if (s_valid && !(sel ? s8_ready : s16_ready)) lowcnt++;
            @(posedge clk);
            #1;
            if (acc) idx++;
            guard++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("drive_done", idx, msg.size());
    endtask

    task automatic wait_obs(input bit s, input int unsigned n);
        int unsigned g;
        g = 0;
        while ((s ? obs8.size() : obs16.size()) < n && g < 4000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 4000) chk("obs_timeout", s ? obs8.size() : obs16.size(), n);
    endtask

    task automatic cmp_cw(input bit s, input int np, input byte_q msg, input string tag,
                          output int unsigned c_first, output int unsigned c_mlast,
                          output int unsigned c_last);
        byte_q       cw, rts;
        rec_t        r;
        logic [7:0]  v;
        int unsigned n;
        ref_codeword(np, msg, cw);
        n = cw.size();
        wait_obs(s, n);
        c_first = 0;
        c_mlast = 0;
        c_last  = 0;
        for (int j = 0; j < n; j++) begin
            if ((s ? obs8.size() : obs16.size()) == 0) break;
            r = s ? obs8.pop_front() : obs16.pop_front();
            chk(tag, {r.d, r.sop, r.eop, r.par},
                {cw[j], (j == 0), (j == n - 1), (j >= msg.size())});
            if (j == 0) c_first = r.cyc;
            if (j == msg.size() - 1) c_mlast = r.cyc;
            c_last = r.cyc;
        end
        rts = (np == 8) ? roots8 : roots16;
        foreach (rts[i]) begin
            v = 8'h00;
            foreach (cw[k]) v = gmul(v, rts[i]) ^ cw[k];
            chk({tag, "_syn"}, v, 8'h00);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        byte_q       msg, m1, m2, cw;
        int unsigned f, ml, l, f2, ml2, l2, low, e0, g;
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        s_last  = 1'b0;
        sel     = 1'b0;
        stall   = 1'b0;
        m_ready = 1'b1;
        find_roots(16, roots16);
        find_roots(8, roots8);

        #2;
        chk("rst_s_ready", s16_ready, 1'b0);
        chk("rst_m_valid", m16_valid, 1'b0);
        chk("rst_m_data", m16_data, 8'h00);
        chk("rst_flags", {m16_sop, m16_eop, m16_par, m16_err}, 4'b0000);
        chk("rst_m_valid8", m8_valid, 1'b0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", s16_ready, 1'b1);
        @(posedge clk);
        #1;

        // Single byte 0x01: parity equals g15..g0
        msg = {8'h01};
        drive(msg, 0, low);
        cmp_cw(0, 16, msg, "len1", f, ml, l);
        chk("len1_cycles", l - f, 16);

        // Full-length all-zero message
        rand_msg(239, msg);
        foreach (msg[i]) msg[i] = 8'h00;
        e0 = err16_cnt;
        drive(msg, 0, low);
        cmp_cw(0, 16, msg, "zero", f, ml, l);
        chk("zero_cycles", l - f, 254);
        chk("zero_err", err16_cnt, e0);
        chk("zero_rdy_low", low, 0);

        // Full-length random message
        rand_msg(239, msg);
        e0 = err16_cnt;
        drive(msg, 0, low);
        cmp_cw(0, 16, msg, "rand239", f, ml, l);
        chk("rand239_err", err16_cnt, e0);

        // NPAR = 8, full-length 247 bytes
        sel = 1'b1;
        rand_msg(247, msg);
        drive(msg, 0, low);
        cmp_cw(1, 8, msg, "n8_247", f, ml, l);
        chk("n8_cycles", l - f, 254);
        chk("n8_err", err8_cnt, 0);
        sel = 1'b0;

        // 240 bytes with no s_last before byte 240: byte 239 is forced last
        rand_msg(240, msg);
        e0 = err16_cnt;
        drive(msg, 0, low);
        m1 = msg[0:238];
        m2 = {msg[239]};
        cmp_cw(0, 16, m1, "force1", f, ml, l);
        chk("force_err_cnt", err16_cnt - e0, 1);
        chk("force_err_cyc", err16_cyc, ml);
        chk("force_rdy_low", low, 16);
        cmp_cw(0, 16, m2, "force2", f2, ml2, l2);
        chk("force_no_bubble", f2, l + 1);

        // Three back-to-back codewords under random input gaps and backpressure
        stall = 1'b1;
        rand_msg($urandom_range(1, 80), m1);
        rand_msg($urandom_range(1, 80), m2);
        rand_msg($urandom_range(1, 80), msg);
        drive(m1, 30, low);
        drive(m2, 30, low);
        drive(msg, 30, low);
        cmp_cw(0, 16, m1, "stall_a", f, ml, l);
        cmp_cw(0, 16, m2, "stall_b", f, ml, l);
        cmp_cw(0, 16, msg, "stall_c", f, ml, l);
        stall = 1'b0;
        @(posedge clk);
        #1;

        // Reset while parity byte 5 is on the output
        rand_msg(20, msg);
        ref_codeword(16, msg, cw);
        drive(msg, 0, low);
        g = 0;
        while (obs16.size() < 24 && g < 1000) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 1000) chk("rst_wait_timeout", obs16.size(), 24);
        #1;
        chk("rst_pre_par", m16_par, 1'b1);
        chk("rst_par5", m16_data, cw[24]);
        rst_n = 1'b0;
        #1;
        chk("arst_valid", m16_valid, 1'b0);
        chk("arst_data", m16_data, 8'h00);
        chk("arst_flags", {m16_sop, m16_eop, m16_par, m16_err}, 4'b0000);
        chk("arst_ready", s16_ready, 1'b0);
        obs16.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        rand_msg(30, msg);
        drive(msg, 0, low);
        cmp_cw(0, 16, msg, "post_rst", f, ml, l);
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_stray", obs16.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rs_encoder_stream.md
# rs_encoder_stream

Parametrised, flow-controlled systematic Reed-Solomon encoder over GF(2^8) with configurable parity length (NPAR = 2T) and runtime-variable (shortened) message length. It accepts message bytes on a valid/ready stream, forwards them unchanged and appends NPAR parity bytes, highest-degree parity byte first. It is the stream-interface successor to the fixed RS(255,239) encoder and sits between the framer and the interleaver in the FEC transmit path.

## Interface
- NPAR, 16: parity bytes per codeword; even, range 2..32. Maximum message length is K_MAX = 255 - NPAR.
- GEN_POLY, 16 coefficients: packed 8*NPAR-bit generator polynomial. Bits [8*i+7:8*i] hold g_i, the coefficient of x^i; x^NPAR is monic and implicit. Default coefficients g0..g15 = 79, 44, 81, 100, 49, 183, 56, 17, 232, 187, 126, 104, 31, 103, 52, 118.
- clk  in  1  sole clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input byte valid.
- s_ready  out  1  encoder can accept a byte.
- s_data  in  8  message byte.
- s_last  in  1  marks the final message byte of a codeword.
- m_valid  out  1  output byte valid.
- m_ready  in  1  downstream accepts the byte.
- m_data  out  8  codeword byte (message, then parity).
- m_sop  out  1  first byte of the codeword.
- m_eop  out  1  last parity byte.
- m_parity  out  1  current byte is parity.
- err_len  out  1  one-cycle pulse: message reached K_MAX bytes without s_last.

## Operation
- Field: GF(2^8), primitive polynomial 0x11D. Constant multipliers are gf256_const_mult instances, one per g_i, generated over NPAR.
- LFSR state: NPAR bytes r[0..NPAR-1].
  - On each accepted message byte d: fb = r[NPAR-1] ^ d, r[0] <= g0*fb, and r[i] <= g_i*fb ^ r[i-1].
- Single output register stage holds m_data, m_sop, m_eop and m_parity. Define the load condition ld = !m_valid | m_ready.
- FSM states:
  - IDLE: s_ready = ld. The first accepted byte starts a codeword and is output with m_sop = 1. Go to MSG, or to PAR if s_last is set on that byte.
  - MSG: s_ready = ld. Each accepted byte updates the LFSR and is loaded into the output register. A byte with s_last, or the K_MAX-th byte, moves the FSM to PAR.
  - PAR: s_ready = 0. On each ld cycle, load m_data = r[NPAR-1], shift r up one byte with zero in at r[0], set m_parity = 1, and decrement the parity counter. The final (NPAR-th) parity byte sets m_eop = 1 and returns to IDLE. The LFSR is all-zero after NPAR shifts.
- Byte counter is 8 bits. It clears in IDLE and counts accepted message bytes.
- Forced end: if the K_MAX-th byte arrives without s_last, treat it as last and pulse err_len in the cycle after acceptance.
- s_last arriving on the K_MAX-th byte is the normal case: no error.
- m_valid stays high while m_ready is low. Output fields are held stable until the byte is accepted.
- m_valid drops after a transfer only if there is no new load.

## Timing
- Reset values: s_ready = 0 during reset, then 1 in the first cycle after deassertion. m_valid, m_sop, m_eop, m_parity, err_len = 0. m_data = 0x00. LFSR = 0, FSM = IDLE, counter = 0.
- Latency: a byte accepted at edge k is presented on m_data after edge k.
- The first parity byte is loaded at the first ld edge after the s_last byte's acceptance.
- Throughput with m_ready held high: a message of L bytes yields L + NPAR output bytes in L + NPAR consecutive cycles. s_ready is low for the NPAR parity cycles.
- Back-to-back codewords: a new message byte is accepted in the cycle after the m_eop byte is loaded, with no bubble when m_ready = 1.
- Reset mid-codeword: all state clears immediately. Any partial codeword is discarded and no m_eop is emitted.

## Test plan
- Message of length 1 (0x01, s_last) with NPAR = 16, m_ready = 1 -> output 0x01 (m_sop = 1), then parity bytes 118, 52, 103, 31, 104, 126, 187, 232, 17, 56, 183, 49, 100, 81, 44, 79 with m_eop on 79.
- 239 zero bytes with s_last on byte 239 -> 239 zero bytes, then 16 zero parity bytes. err_len stays 0. 255 cycles total.
- 239 random bytes -> parity matches the software RS(255,239) model, and the syndrome of the full codeword is 0. Repeat with NPAR = 8 and a matching GEN_POLY against a 247-byte message.
- 240 bytes without s_last -> byte 239 is forced last and err_len pulses once. s_ready is low for 16 cycles. Byte 240 is then accepted as the start of a new codeword with m_sop = 1.
- Random m_ready and s_valid gaps across three back-to-back codewords -> output byte stream is identical to the no-stall run, and m_data is stable while m_valid = 1 and m_ready = 0.
- rst_n asserted during parity byte 5 -> outputs go to reset values asynchronously. The next codeword encodes correctly from a cleared LFSR.
